// File: rtl/mdio_pkg.sv
// -----------------------------------------------------------------------------
// mdio_pkg
// Shared definitions for the MDIO transaction arbiter:
//   - Clause-22 frame constants (start, opcode, turnaround codes)
//   - bit offsets of each frame field inside the 32-bit frame
//   - arbiter FSM state encoding
//   - build_frame(): packs one request into a 32-bit Clause-22 frame
// -----------------------------------------------------------------------------
package mdio_pkg;

  // Frame field codes
  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;
  localparam logic [1:0] TA_READ  = 2'b11;

  // Field LSB positions inside the 32-bit frame
  localparam int ST_LSB   = 30;
  localparam int OP_LSB   = 28;
  localparam int PHY_LSB  = 23;
  localparam int REG_LSB  = 18;
  localparam int TA_LSB   = 16;
  localparam int DATA_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_t;

  // Read frames carry zero in the data field; the PHY drives it on the wire.
  function automatic logic [31:0] build_frame(input logic        write,
                                              input logic [4:0]  phyad,
                                              input logic [4:0]  regad,
                                              input logic [15:0] wdata);
    logic [31:0] f;
    f                   = '0;
    f[ST_LSB   +: 2]    = ST_CODE;
    f[OP_LSB   +: 2]    = write ? OP_WRITE : OP_READ;
    f[PHY_LSB  +: 5]    = phyad;
    f[REG_LSB  +: 5]    = regad;
    f[TA_LSB   +: 2]    = write ? TA_WRITE : TA_READ;
    f[DATA_LSB +: 16]   = write ? wdata : 16'h0000;
    return f;
  endfunction

endpackage

// File: rtl/mdio_rr_arb.sv
// -----------------------------------------------------------------------------
// mdio_rr_arb
// Combinational round-robin grant. Searches req starting at ptr and wrapping
// upward; the first set bit wins.
// Ports:
//   req    in  NREQ  request vector
//   ptr    in  2     highest-priority index (0..NREQ-1)
//   grant  out NREQ  one-hot grant (all zero when no request)
//   index  out 2     index of the winner (0 when no request)
//   any    out 1     at least one request present
// -----------------------------------------------------------------------------
module mdio_rr_arb #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      index,
  output logic            any
);

  // Padded to four entries so a 2-bit index is always in range.
  logic [3:0] req_pad;
  logic [1:0] idx;

  // NOTE: every signal written in an always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    req_pad = 4'(req);
    grant   = '0;
    index   = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = 2'((int'(ptr) + i) % NREQ);
      if (!any && req_pad[idx]) begin
        any   = 1'b1;
        index = idx;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      grant[j] = any && (index == 2'(j));
    end
  end

endmodule

// File: rtl/mdio_txn_arbiter.sv
// -----------------------------------------------------------------------------
// mdio_txn_arbiter
// Shares one MDIO master between NREQ requesters. Round-robin arbitration,
// packs the winner's request into a Clause-22 frame, launches it with a
// one-cycle mst_start, waits for mst_done and returns read data / write ack
// to the owning requester, then enforces IFG_CYCLES idle cycles.
//
// Build option: define MDIO_TIMEOUT_EN to add a WAIT-state watchdog that
// completes the transaction with rsp_err=1 after TIMEOUT_CYCLES.
//
// Ports:
//   clk          in   clock, posedge
//   reset        in   asynchronous active-low reset
//   req_valid    in   NREQ     request pending per requester
//   req_write    in   NREQ     1=write, 0=read
//   req_phyad    in   5*NREQ   PHY address, requester i at [5i+4:5i]
//   req_regad    in   5*NREQ   register address, requester i at [5i+4:5i]
//   req_wdata    in   16*NREQ  write data, requester i at [16i+15:16i]
//   req_ready    out  NREQ     one-cycle accept pulse to the winner
//   rsp_valid    out  NREQ     one-cycle completion pulse to the owner
//   rsp_rdata    out  16       read data (0 for writes)
//   rsp_err      out  1        watchdog timeout flag
//   mst_start    out  1        one-cycle launch pulse to the MDIO master
//   mst_frame    out  32       frame, held until the next grant
//   mst_done     in   1        master finished the frame (honoured in WAIT only)
//   mst_rd_data  in   16       master read data, sampled on mst_done
//   busy         out  1        FSM not in IDLE
//   owner        out  2        current or last granted requester
// -----------------------------------------------------------------------------
module mdio_txn_arbiter
  import mdio_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int IFG_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [5*NREQ-1:0]  req_phyad,
  input  logic [5*NREQ-1:0]  req_regad,
  input  logic [16*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [15:0]        rsp_rdata,
  output logic               rsp_err,
  output logic               mst_start,
  output logic [31:0]        mst_frame,
  input  logic               mst_done,
  input  logic [15:0]        mst_rd_data,
  output logic               busy,
  output logic [1:0]         owner
);

  if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYCLES < 1 || IFG_CYCLES < 0) begin : g_param_check
    $error("mdio_txn_arbiter: unsupported parameter values");
  end

  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q;
  logic [1:0]         owner_q;
  logic               write_q;
  logic [31:0]        frame_q;
  logic [15:0]        rdata_q;
  logic               err_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               gap_last;
  logic               timeout;

  logic [NREQ-1:0]    arb_grant;
  logic [1:0]         arb_index;
  logic               arb_any;

  // Request fields padded to four requesters so a 2-bit index never overruns.
  logic [3:0]         write_pad;
  logic [19:0]        phy_pad;
  logic [19:0]        reg_pad;
  logic [63:0]        wdata_pad;

  assign write_pad = 4'(req_write);
  assign phy_pad   = 20'(req_phyad);
  assign reg_pad   = 20'(req_regad);
  assign wdata_pad = 64'(req_wdata);

  assign gap_last  = (gap_cnt_q == GAP_W'(IFG_CYCLES - 1));

  mdio_rr_arb #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .index (arb_index),
    .any   (arb_any)
  );

`ifdef MDIO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt_q;

  // Counter reads k in the k-th cycle after the launch cycle, so the
  // response lands TIMEOUT_CYCLES+1 cycles after mst_start.
  assign timeout = (state_q == S_WAIT) && (wait_cnt_q >= TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_LAUNCH) begin
      wait_cnt_q <= TW'(1);
    end else if (state_q == S_WAIT && !timeout) begin
      wait_cnt_q <= wait_cnt_q + TW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (arb_any) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (mst_done || timeout) state_d = S_RESP;
      S_RESP:   state_d = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:    if (gap_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q     <= '0;
      owner_q   <= '0;
      write_q   <= 1'b0;
      frame_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arb_any) begin
            owner_q <= arb_index;
            write_q <= write_pad[arb_index];
            frame_q <= build_frame(write_pad[arb_index],
                                   phy_pad[5*int'(arb_index) +: 5],
                                   reg_pad[5*int'(arb_index) +: 5],
                                   wdata_pad[16*int'(arb_index) +: 16]);
          end
        end
        S_WAIT: begin
          // A real completion wins over a watchdog expiry in the same cycle.
          if (mst_done) begin
            rdata_q <= write_q ? 16'h0000 : mst_rd_data;
            err_q   <= 1'b0;
          end else if (timeout) begin
            rdata_q <= 16'h0000;
            err_q   <= 1'b1;
          end
        end
        S_RESP: begin
          ptr_q     <= (owner_q == 2'(NREQ - 1)) ? 2'd0 : owner_q + 2'd1;
          gap_cnt_q <= '0;
        end
        S_GAP: begin
          gap_cnt_q <= gap_cnt_q + GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  // req_ready is a combinational accept so the requester sees it in the same
  // cycle the grant is latched; it is forced low while reset is held.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == S_IDLE && reset) begin
      req_ready = arb_grant;
    end
    for (int j = 0; j < NREQ; j++) begin
      rsp_valid[j] = (state_q == S_RESP) && (owner_q == 2'(j));
    end
  end

  assign mst_start = (state_q == S_LAUNCH);
  assign busy      = (state_q != S_IDLE);
  assign mst_frame = frame_q;
  assign owner     = owner_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
